// File: rtl/light_conflict_monitor.sv
// -----------------------------------------------------------------------------
// light_conflict_monitor
//
// Safety stage that sits directly after the traffic controller. Valid lamp
// aspects are passed to the lamp drivers with one cycle of latency. Any cycle
// with a suspect aspect drives all-red. A conflict that persists for
// FILTER_CYCLES consecutive cycles, or a controller whose outputs do not change
// for STUCK_CYCLES cycles, latches a flashing-red failsafe. The failsafe is
// left only through reset or an operator clear issued on a clean input cycle.
//
// Ports:
//   clk                      system clock
//   reset                    asynchronous, active-high reset
//   Rm, Ym, Gm               main-road lamp requests from the controller
//   Rs, Ys, Gs               side-road lamp requests from the controller
//   W                        walk lamp request from the controller
//   fault_clear              synchronous operator clear pulse
//   Rm_out .. W_out          registered lamp drives
//   fault                    high while the failsafe is latched
//   fault_code[2:0]          latched cause: 000 none, 001 cross conflict,
//                            010 walk conflict, 011 invalid aspect, 100 stuck
//
// FILTER_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module light_conflict_monitor #(
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned FLASH_HALF    = 500,
    parameter int unsigned STUCK_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rm,
    input  logic       Ym,
    input  logic       Gm,
    input  logic       Rs,
    input  logic       Ys,
    input  logic       Gs,
    input  logic       W,
    input  logic       fault_clear,
    output logic       Rm_out,
    output logic       Ym_out,
    output logic       Gm_out,
    output logic       Rs_out,
    output logic       Ys_out,
    output logic       Gs_out,
    output logic       W_out,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int unsigned FILT_W  = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned FLASH_W = $clog2(FLASH_HALF + 1);
    localparam int unsigned STUCK_W = $clog2(STUCK_CYCLES + 1);

    // Lamp vector ordering everywhere: {Rm, Ym, Gm, Rs, Ys, Gs, W}
    localparam logic [6:0] ALL_RED = 7'b100_100_0;

    localparam logic [2:0] CODE_NONE    = 3'b000;
    localparam logic [2:0] CODE_CROSS   = 3'b001;
    localparam logic [2:0] CODE_WALK    = 3'b010;
    localparam logic [2:0] CODE_INVALID = 3'b011;
    localparam logic [2:0] CODE_STUCK   = 3'b100;

    typedef enum logic [1:0] {
        ST_PASS    = 2'd0,
        ST_PENDING = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // A road head must show exactly one of red/yellow/green
    function automatic logic one_hot3(input logic [2:0] v);
        case (v)
            3'b001, 3'b010, 3'b100: one_hot3 = 1'b1;
            default:                one_hot3 = 1'b0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [6:0]         lamps_q, lamps_d;
    logic               fault_q, fault_d;
    logic [2:0]         code_q, code_d;
    logic [FILT_W-1:0]  filter_q, filter_d;
    logic [STUCK_W-1:0] stuck_q, stuck_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               phase_q, phase_d;
    logic [6:0]         prev_q, prev_d;

    logic [6:0]         lamps_in_s;
    logic               cross_s;
    logic               walk_s;
    logic               invalid_s;
    logic               viol_s;
    logic [2:0]         viol_code_s;
    logic [STUCK_W-1:0] stuck_next_s;
    logic               stuck_trip_s;
    logic [FILT_W-1:0]  filter_inc_s;
    logic               filter_trip_s;
    logic               trip_s;
    logic [2:0]         trip_code_s;

    // Classify the current input aspect and pick the highest-priority cause
    always_comb begin
        lamps_in_s = {Rm, Ym, Gm, Rs, Ys, Gs, W};
        cross_s    = (Gm | Ym) & (Gs | Ys);
        walk_s     = W & (Gm | Ym | Gs | Ys);
        invalid_s  = ~one_hot3({Rm, Ym, Gm}) | ~one_hot3({Rs, Ys, Gs});
        viol_s     = cross_s | walk_s | invalid_s;
        if (cross_s) begin
            viol_code_s = CODE_CROSS;
        end else if (walk_s) begin
            viol_code_s = CODE_WALK;
        end else if (invalid_s) begin
            viol_code_s = CODE_INVALID;
        end else begin
            viol_code_s = CODE_NONE;
        end
    end

    // Stuck watchdog next value (saturating) and filter increment
    always_comb begin
        if (lamps_in_s != prev_q) begin
            stuck_next_s = STUCK_W'(0);
        end else if (stuck_q < STUCK_W'(STUCK_CYCLES)) begin
            stuck_next_s = stuck_q + STUCK_W'(1);
        end else begin
            stuck_next_s = stuck_q;
        end
        stuck_trip_s = (stuck_next_s == STUCK_W'(STUCK_CYCLES));
        filter_inc_s = filter_q + FILT_W'(1);
    end

    // Decide whether this edge latches the failsafe, and with which code.
    // A filter trip outranks a simultaneous stuck trip.
    always_comb begin
        filter_trip_s = 1'b0;
        case (state_q)
            ST_PASS:    filter_trip_s = viol_s & (FILTER_CYCLES == 32'd1);
            ST_PENDING: filter_trip_s = viol_s & (filter_inc_s == FILT_W'(FILTER_CYCLES));
            default:    filter_trip_s = 1'b0;
        endcase
        trip_s = filter_trip_s | (stuck_trip_s & (state_q != ST_FAULT));
        if (filter_trip_s) begin
            trip_code_s = viol_code_s;
        end else begin
            trip_code_s = CODE_STUCK;
        end
    end

    // Next-state, counter and lamp-drive computation
    always_comb begin
        state_d     = state_q;
        lamps_d     = ALL_RED;
        fault_d     = fault_q;
        code_d      = code_q;
        filter_d    = filter_q;
        stuck_d     = stuck_q;
        flash_cnt_d = flash_cnt_q;
        phase_d     = phase_q;
        prev_d      = lamps_in_s;

        if (trip_s) begin
            state_d     = ST_FAULT;
            fault_d     = 1'b1;
            code_d      = trip_code_s;
            filter_d    = FILT_W'(0);
            stuck_d     = STUCK_W'(0);
            flash_cnt_d = FLASH_W'(0);
            phase_d     = 1'b1;
            lamps_d     = ALL_RED;
        end else begin
            case (state_q)
                ST_PASS: begin
                    stuck_d = stuck_next_s;
                    if (viol_s) begin
                        state_d  = ST_PENDING;
                        filter_d = FILT_W'(1);
                        lamps_d  = ALL_RED;
                    end else begin
                        filter_d = FILT_W'(0);
                        lamps_d  = lamps_in_s;
                    end
                end
                ST_PENDING: begin
                    if (viol_s) begin
                        filter_d = filter_inc_s;
                        stuck_d  = stuck_next_s;
                        lamps_d  = ALL_RED;
                    end else begin
                        // Clean cycle: resume pass-through on this very edge
                        state_d  = ST_PASS;
                        filter_d = FILT_W'(0);
                        stuck_d  = STUCK_W'(0);
                        lamps_d  = lamps_in_s;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear && !viol_s) begin
                        // One all-red cycle before pass-through resumes
                        state_d     = ST_PASS;
                        fault_d     = 1'b0;
                        code_d      = CODE_NONE;
                        filter_d    = FILT_W'(0);
                        stuck_d     = STUCK_W'(0);
                        flash_cnt_d = FLASH_W'(0);
                        phase_d     = 1'b0;
                        lamps_d     = ALL_RED;
                    end else begin
                        if (flash_cnt_q == FLASH_W'(FLASH_HALF - 1)) begin
                            flash_cnt_d = FLASH_W'(0);
                            phase_d     = ~phase_q;
                        end else begin
                            flash_cnt_d = flash_cnt_q + FLASH_W'(1);
                            phase_d     = phase_q;
                        end
                        lamps_d = {phase_d, 1'b0, 1'b0, phase_d, 1'b0, 1'b0, 1'b0};
                    end
                end
                default: begin
                    state_d     = ST_PASS;
                    fault_d     = 1'b0;
                    code_d      = CODE_NONE;
                    filter_d    = FILT_W'(0);
                    stuck_d     = STUCK_W'(0);
                    flash_cnt_d = FLASH_W'(0);
                    phase_d     = 1'b0;
                    lamps_d     = ALL_RED;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PASS;
            lamps_q     <= ALL_RED;
            fault_q     <= 1'b0;
            code_q      <= CODE_NONE;
            filter_q    <= FILT_W'(0);
            stuck_q     <= STUCK_W'(0);
            flash_cnt_q <= FLASH_W'(0);
            phase_q     <= 1'b0;
            prev_q      <= 7'b000_000_0;
        end else begin
            state_q     <= state_d;
            lamps_q     <= lamps_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            filter_q    <= filter_d;
            stuck_q     <= stuck_d;
            flash_cnt_q <= flash_cnt_d;
            phase_q     <= phase_d;
            prev_q      <= prev_d;
        end
    end

    assign Rm_out     = lamps_q[6];
    assign Ym_out     = lamps_q[5];
    assign Gm_out     = lamps_q[4];
    assign Rs_out     = lamps_q[3];
    assign Ys_out     = lamps_q[2];
    assign Gs_out     = lamps_q[1];
    assign W_out      = lamps_q[0];
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule
